phase_scheduler: RTL and testbench

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

---
 rtl/phase_scheduler_pkg.sv | 25 ++
 rtl/phase_scheduler_rr_arbiter4.sv | 24 ++
 rtl/phase_scheduler.sv | 104 ++++++++++
 tb/tb_phase_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_scheduler_pkg.sv
// phase_scheduler_pkg: light codes, FSM state encoding and phase indices shared by the scheduler.
package phase_scheduler_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_GREEN  = 2'b01;
    localparam logic [1:0] S_YELLOW = 2'b10;
    localparam logic [1:0] S_ALLRED = 2'b11;

    localparam logic [1:0] PH_NS  = 2'd0;
    localparam logic [1:0] PH_EW  = 2'd1;
    localparam logic [1:0] PH_NSL = 2'd2;
    localparam logic [1:0] PH_EWL = 2'd3;

    // Packed {ewl, nsl, ew, ns} light codes; only the granted phase can be non-red.
    function automatic logic [7:0] light_vec(input logic [1:0] st, input logic [1:0] ph);
        logic [1:0] code;
        code = st == S_GREEN ? GREEN : st == S_YELLOW ? YELLOW : RED;
        light_vec = {6'b0, code} << {ph, 1'b0};
    endfunction

endpackage

// File: rtl/phase_scheduler_rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter, search starts one past the last granted phase.
module rr_arbiter4 (
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = 2'(last + 2'(k));
            if (pending[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: four-phase traffic light FSM with round-robin service and tick-based timers.
// Optional pedestrian WALK support is enabled by defining PHASE_SCHED_PED_WALK_EN.
module phase_scheduler
    import phase_scheduler_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       ped_ns,
    input  logic       ped_ew,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic [1:0] nsl_light,
    output logic [1:0] ewl_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [1:0] phase,
    output logic [1:0] state
);

    logic [1:0] state_n, phase_n, last_q, gnt, walk_q;
    logic [7:0] timer_q, timer_n, lights_q;
    logic [8:0] cnt;
    logic [3:0] dem_q, ped_req, pend, served;
    logic       gv, enter, others, done_green;

`ifdef PHASE_SCHED_PED_WALK_EN
    logic [1:0] ped_q, ped_live, take;
    assign ped_live = ped_q | {ped_ew, ped_ns};
    assign ped_req  = {2'b00, ped_live};
    assign take     = {enter && phase_n == PH_EW, enter && phase_n == PH_NS};
    always_ff @(posedge CLK)
        if (rst) begin
            ped_q  <= '0;
            walk_q <= '0;
        end else begin
            ped_q <= ped_live & ~take;
            for (int i = 0; i < 2; i++)
                walk_q[i] <= take[i] ? ped_live[i]
                           : walk_q[i] && state_n == S_GREEN && !(tick && cnt >= 9'(GREEN_MIN));
        end
`else
    logic unused_ped;
    assign unused_ped = ped_ns ^ ped_ew;
    assign ped_req    = '0;
    assign walk_q     = '0;
`endif

    assign pend = req | dem_q | ped_req;

    rr_arbiter4 u_arb (.pending(pend), .last(last_q), .grant(gnt), .valid(gv));

    assign cnt        = {1'b0, timer_q} + 9'd1;
    assign others     = |(pend & ~(4'b0001 << phase));
    assign done_green = cnt >= 9'(GREEN_MAX) || (cnt >= 9'(GREEN_MIN) && (!req[phase] || others));

    always_comb begin
        state_n = state;
        phase_n = phase;
        enter   = 1'b0;
        case (state)
            S_IDLE:   if (gv) begin state_n = S_GREEN; phase_n = gnt; enter = 1'b1; end
            S_GREEN:  if (tick && done_green) state_n = S_YELLOW;
            S_YELLOW: if (tick && cnt >= 9'(YELLOW_T)) state_n = S_ALLRED;
            default:  if (tick && cnt >= 9'(ALLRED_T)) begin
                state_n = gv ? S_GREEN : S_IDLE;
                phase_n = gv ? gnt : phase;
                enter   = gv;
            end
        endcase
    end

    // Timer restarts on every state change and saturates instead of wrapping.
    assign timer_n = (state_n != state || enter || state == S_IDLE) ? 8'd0
                   : (tick && timer_q != 8'hFF) ? timer_q + 8'd1 : timer_q;
    assign served  = state_n == S_GREEN ? 4'b0001 << phase_n : 4'b0000;

    always_ff @(posedge CLK)
        if (rst) begin
            state    <= S_IDLE;
            phase    <= PH_NS;
            last_q   <= PH_EWL;
            timer_q  <= '0;
            dem_q    <= '0;
            lights_q <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            last_q   <= enter ? phase_n : last_q;
            timer_q  <= timer_n;
            dem_q    <= (dem_q | req) & ~served;
            lights_q <= light_vec(state_n, phase_n);
        end

    assign {ewl_light, nsl_light, ew_light, ns_light} = lights_q;
    assign {walk_ew, walk_ns} = walk_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: directed spec scenarios plus randomized traffic against a behavioural model.
module tb_phase_scheduler;

    localparam int GMIN = 5, GMAX = 20, YT = 3, AT = 2;

    logic       clk = 1'b0, rst = 1'b1, tick = 1'b1, ped_ns = 1'b0, ped_ew = 1'b0;
    logic [3:0] req = 4'b0;
    logic [1:0] ns_light, ew_light, nsl_light, ewl_light, phase, state;
    logic       walk_ns, walk_ew;
    int         compared = 0, mismatched = 0;

    int       m_mode = 0, m_ph = 0, m_last = 3, m_t = 0;
    bit [3:0] m_dem = '0;
    bit [1:0] m_pedl = '0, m_walkg = '0;

    always #5 clk = ~clk;

    phase_scheduler dut (
        .CLK(clk), .rst(rst), .tick(tick), .req(req), .ped_ns(ped_ns), .ped_ew(ped_ew),
        .ns_light(ns_light), .ew_light(ew_light), .nsl_light(nsl_light), .ewl_light(ewl_light),
        .walk_ns(walk_ns), .walk_ew(walk_ew), .phase(phase), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef PHASE_SCHED_PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    // Model: modes 0 idle, 1 green, 2 yellow, 3 allred; m_t counts ticks spent in the mode.
    task automatic model_step();
        bit [3:0] p;
        bit [1:0] pin;
        int       g, entered;
        bit       oth;
        if (rst) begin
            m_mode = 0; m_ph = 0; m_last = 3; m_t = 0; m_dem = '0; m_pedl = '0; m_walkg = '0;
            return;
        end
        pin = PED ? {ped_ew, ped_ns} : 2'b00;
        for (int i = 0; i < 4; i++)
            p[i] = req[i] | m_dem[i] | (i < 2 ? (m_pedl[i] | pin[i]) : 1'b0);
        g = -1;
        for (int off = 1; off <= 4; off++)
            if (g < 0 && p[(m_last + off) % 4]) g = (m_last + off) % 4;
        entered = -1;
        case (m_mode)
            0: if (g >= 0) entered = g;
            1: if (tick) begin
                m_t++;
                oth = 1'b0;
                for (int j = 0; j < 4; j++) if (j != m_ph && p[j]) oth = 1'b1;
                if (m_t >= GMAX || (m_t >= GMIN && (!req[m_ph] || oth))) begin m_mode = 2; m_t = 0; end
            end
            2: if (tick) begin m_t++; if (m_t >= YT) begin m_mode = 3; m_t = 0; end end
            default: if (tick) begin
                m_t++;
                if (m_t >= AT) begin
                    if (g >= 0) entered = g;
                    else begin m_mode = 0; m_t = 0; end
                end
            end
        endcase
        if (entered >= 0) begin m_mode = 1; m_ph = entered; m_last = entered; m_t = 0; end
        for (int i = 0; i < 4; i++)
            m_dem[i] = (m_mode == 1 && m_ph == i) ? 1'b0 : (m_dem[i] | req[i]);
        for (int i = 0; i < 2; i++)
            if (entered == i) begin m_walkg[i] = m_pedl[i] | pin[i]; m_pedl[i] = 1'b0; end
            else m_pedl[i] = m_pedl[i] | pin[i];
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [1:0] lv[4];
        int nonred;
        @(negedge clk);
        lv = '{ns_light, ew_light, nsl_light, ewl_light};
        check("state", state, m_mode);
        check("phase", phase, m_ph);
        nonred = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("light%0d", i), lv[i], (m_mode == 1 && m_ph == i) ? 2 : (m_mode == 2 && m_ph == i) ? 1 : 0);
            if (lv[i] !== 2'b00) nonred++;
        end
        check("conflict", nonred <= 1, 1);
        check("walk_ns", walk_ns, m_walkg[0] && m_mode == 1 && m_ph == 0 && m_t < GMIN);
        check("walk_ew", walk_ew, m_walkg[1] && m_mode == 1 && m_ph == 1 && m_t < GMIN);
    end

    function automatic logic [1:0] sig(input int w);
        case (w)
            0: return ns_light;
            1: return ew_light;
            2: return nsl_light;
            3: return ewl_light;
            4: return state;
            default: return {1'b0, walk_ns};
        endcase
    endfunction

    task automatic wait_for(input int w, input logic [1:0] code, input string name);
        int n = 0;
        while (sig(w) !== code && n < 400) begin @(negedge clk); n++; end
        check(name, sig(w), code);
    endtask

    task automatic run_len(input int w, input logic [1:0] code, output int n);
        n = 0;
        while (sig(w) === code && n < 400) begin n++; @(negedge clk); end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; tick = 1'b1; ped_ns = 1'b0; ped_ew = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_phase", phase, 0);
        check("rst_lights", {ns_light, ew_light, nsl_light, ewl_light}, 0);
        check("rst_walk", {walk_ns, walk_ew}, 0);

        rst = 1'b0; req = 4'b0001;
        wait_for(0, 2'b10, "r034_green_start");
        run_len(0, 2'b10, n); check("r034_green_len", n, 20);
        run_len(0, 2'b01, n); check("r034_yellow_len", n, 3);
        run_len(4, 2'b11, n); check("r034_allred_len", n, 2);
        check("r034_regreen", ns_light, 2'b10);

        do_reset();
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_for(0, 2'b10, "r035_green_start");
        run_len(0, 2'b10, n); check("r035_green_len", n, 5);
        run_len(0, 2'b01, n); check("r035_yellow_len", n, 3);
        run_len(4, 2'b11, n); check("r035_allred_len", n, 2);
        check("r035_idle", state, 0);

        do_reset();
        req = 4'b1111;
        foreach (exp_seq[k]) begin
            wait_for(4, 2'b01, "r036_green");
            check("r036_phase", phase, exp_seq[k]);
            run_len(4, 2'b01, n); check("r036_green_len", n, 5);
        end

        do_reset();
        req = 4'b0001;
        wait_for(4, 2'b01, "r037_green");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("r037_state", state, 0);
        check("r037_lights", {ns_light, ew_light, nsl_light, ewl_light}, 0);
        check("r037_phase", phase, 0);
        rst = 1'b0; req = 4'b0000;

        do_reset();
        req = 4'b0010;
        wait_for(4, 2'b01, "r039_green");
        tick = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("r039_hold", {state, phase, ew_light}, {2'b01, 2'b01, 2'b10});
        end
        tick = 1'b1; req = 4'b0000;

`ifdef PHASE_SCHED_PED_WALK_EN
        do_reset();
        req = 4'b0010;
        wait_for(4, 2'b01, "r038_green1");
        ped_ns = 1'b1;
        @(negedge clk);
        ped_ns = 1'b0; req = 4'b0000;
        wait_for(0, 2'b10, "r038_green0");
        run_len(5, 2'b01, n); check("r038_walk_len", n, 5);
`endif

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            tick   = $urandom_range(0, 3) != 0;
            ped_ns = $urandom_range(0, 19) == 0;
            ped_ew = $urandom_range(0, 19) == 0;
            rst    = $urandom_range(0, 599) == 0;
        end
        rst = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
